// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and helpers for the instruction/data memory-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, I_BUSY, D_BUSY)
//   owner_t     : which requester won arbitration (OWN_I, OWN_D)
//   pick_inst_word : selects the 32-bit instruction word out of a 64-bit beat
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int INST_W   = 32;
  // Streak counter is 4 bits wide, enough for MAX_D_STREAK up to 15.
  localparam int STREAK_W = 4;

  // Byte address bit 2 chooses the upper or lower instruction in a 64-bit beat.
  function automatic logic [INST_W-1:0] pick_inst_word(input logic [63:0] beat,
                                                       input logic        hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// arb_timer
//   Watchdog for an outstanding memory request.
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the count (pulsed on every grant)
//   enable   : one cycle of m_req high is being spent
//   expired  : the count reaches TIMEOUT at the end of this enabled cycle,
//              i.e. this is the TIMEOUT-th cycle of the request
module arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // count_reg holds the number of request cycles already completed; the cycle
  // in progress takes it to count_next. Saturates so it can never wrap.
  always_comb begin
    count_next = count_reg;
    if (enable && (count_reg != CNT_W'(TIMEOUT))) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = enable && (count_next == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between instruction fetch and data access.
//   One transaction is outstanding at a time; data normally wins, but after
//   MAX_D_STREAK consecutive data grants with a fetch waiting, the fetch wins.
//   A watchdog aborts a request that sees no m_ack within TIMEOUT cycles.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     i_req/i_addr             : fetch request (held until i_gnt)
//     i_gnt                    : fetch accepted (combinational, IDLE only)
//     i_rvalid/i_rdata/i_err   : fetch completion pulse, word, timeout flag
//     d_req/d_we/d_addr/d_wdata: data request (held until d_gnt)
//     d_gnt                    : data accepted (combinational, IDLE only)
//     d_rvalid/d_rdata/d_err   : data completion pulse, load data, timeout flag
//     m_req/m_we/m_addr/m_wdata: memory request, held until ack or timeout
//     m_ack/m_rdata            : memory completion, read data same cycle
//   DATA_W must be at least 64 (instruction words come from bits 63:0).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_t state_reg;
  arb_state_t state_next;

  logic [STREAK_W-1:0] streak_reg;
  logic [STREAK_W-1:0] streak_next;
  logic                streak_full;

  owner_t winner;
  logic   grant;
  logic   busy;
  logic   expired;
  logic   finish;

  logic              m_req_reg;
  logic              m_we_reg;
  logic [ADDR_W-1:0] m_addr_reg;
  logic [DATA_W-1:0] m_wdata_reg;
  logic              i_hi_reg;

  logic              i_rvalid_reg;
  logic              i_err_reg;
  logic [31:0]       i_rdata_reg;
  logic              d_rvalid_reg;
  logic              d_err_reg;
  logic [DATA_W-1:0] d_rdata_reg;

  // ---------------------------------------------------------------- watchdog
  arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant),
    .enable (m_req_reg),
    .expired(expired)
  );

  assign busy   = (state_reg != IDLE);
  // An ack in the TIMEOUT-th cycle still completes normally; the error path
  // below only looks at expired when m_ack is low.
  assign finish = busy && (m_ack || expired);

  // ------------------------------------------------------ FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------- FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next = (winner == OWN_D) ? D_BUSY : I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (m_ack || expired) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------- FSM: output/arbitration
  always_comb begin
    streak_full = (streak_reg == STREAK_W'(MAX_D_STREAK));
    // Data wins unless a fetch has been starved for a full streak.
    if (d_req && !(i_req && streak_full)) begin
      winner = OWN_D;
    end else begin
      winner = OWN_I;
    end
    // Grants are suppressed during reset so nothing is handed out that the
    // reset would then discard.
    grant = (state_reg == IDLE) && !rst && (i_req || d_req);
    i_gnt = grant && (winner == OWN_I);
    d_gnt = grant && (winner == OWN_D);
  end

  // Streak only grows while a fetch is actually waiting behind the data grant.
  always_comb begin
    streak_next = streak_reg;
    if (i_gnt) begin
      streak_next = '0;
    end else if (d_gnt) begin
      if (!i_req) begin
        streak_next = '0;
      end else if (!streak_full) begin
        streak_next = streak_reg + 1'b1;
      end
    end
  end

  // ------------------------------------------- request and response datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_reg   <= '0;
      m_req_reg    <= 1'b0;
      m_we_reg     <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      i_hi_reg     <= 1'b0;
      i_rvalid_reg <= 1'b0;
      i_err_reg    <= 1'b0;
      i_rdata_reg  <= '0;
      d_rvalid_reg <= 1'b0;
      d_err_reg    <= 1'b0;
      d_rdata_reg  <= '0;
    end else begin
      streak_reg   <= streak_next;
      i_rvalid_reg <= 1'b0;
      i_err_reg    <= 1'b0;
      d_rvalid_reg <= 1'b0;
      d_err_reg    <= 1'b0;

      if (grant) begin
        m_req_reg <= 1'b1;
        if (winner == OWN_D) begin
          m_addr_reg  <= d_addr;
          m_we_reg    <= d_we;
          m_wdata_reg <= d_wdata;
        end else begin
          m_addr_reg  <= i_addr;
          m_we_reg    <= 1'b0;
          m_wdata_reg <= '0;
          i_hi_reg    <= i_addr[2];
        end
      end else if (finish) begin
        m_req_reg <= 1'b0;
      end

      if (finish) begin
        if (state_reg == I_BUSY) begin
          i_rvalid_reg <= 1'b1;
          i_err_reg    <= !m_ack;
          i_rdata_reg  <= m_ack ? pick_inst_word(m_rdata[63:0], i_hi_reg) : 32'd0;
        end else begin
          d_rvalid_reg <= 1'b1;
          d_err_reg    <= !m_ack;
          // Stores leave the last load result in place.
          if (!m_ack) begin
            d_rdata_reg <= '0;
          end else if (!m_we_reg) begin
            d_rdata_reg <= m_rdata;
          end
        end
      end
    end
  end

  assign m_req    = m_req_reg;
  assign m_we     = m_we_reg;
  assign m_addr   = m_addr_reg;
  assign m_wdata  = m_wdata_reg;
  assign i_rvalid = i_rvalid_reg;
  assign i_err    = i_err_reg;
  assign i_rdata  = i_rdata_reg;
  assign d_rvalid = d_rvalid_reg;
  assign d_err    = d_err_reg;
  assign d_rdata  = d_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter: expected completions are queued at grant
//   time and compared when the arbiter pulses rvalid. Inputs change 1 time unit
//   after posedge; outputs are sampled on negedge.
module tb_mem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  typedef struct {
    bit          is_d;
    bit          err;
    logic [63:0] data;
    int          k;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  bit   gnt_log[$];
  int   gnt_cyc[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rv_total = 0;

  // memory responder configuration: ack after ack_delay cycles of m_req,
  // 0 means never ack
  logic [63:0] mem_rdata;
  int          ack_delay;
  bit          force_ack;
  int          req_cnt;
  bit          i_hold, d_hold;
  bit          saw_i_gnt, saw_d_gnt;

  // expected request fields and last expected load result
  logic [63:0] model_d;
  logic [63:0] exp_addr, exp_wdata;
  logic        exp_we;
  int          req_hi;

  task automatic check_value(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    saw_i_gnt = i_gnt && !rst;
    saw_d_gnt = d_gnt && !rst;
    if (!rst) begin
      check_value("err_gate", {62'd0, i_err & ~i_rvalid, d_err & ~d_rvalid}, 64'd0);

      if (i_rvalid || d_rvalid) begin
        rv_total++;
        if (sb.size() == 0) begin
          check_value("unexp_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check_value("rv_kind", {62'd0, i_rvalid, d_rvalid}, e.is_d ? 64'd1 : 64'd2);
          check_value("rv_cycle", 64'(cyc), 64'(e.cyc));
          check_value("mreq_len", 64'(req_hi), 64'(e.k));
          if (e.is_d) begin
            check_value("d_err", {63'd0, d_err}, {63'd0, e.err});
            check_value("d_rdata", d_rdata, e.data);
          end else begin
            check_value("i_err", {63'd0, i_err}, {63'd0, e.err});
            check_value("i_rdata", {32'd0, i_rdata}, e.data);
          end
          $display("txn %s err=%0d data=%h cyc=%0d", e.is_d ? "D" : "I", e.err, e.data, cyc);
        end
      end

      if (i_gnt || d_gnt) begin
        check_value("one_gnt", {63'd0, i_gnt & d_gnt}, 64'd0);
        e.is_d = d_gnt;
        e.err  = !(ack_delay >= 1 && ack_delay <= TO);
        e.k    = e.err ? TO : ack_delay;
        e.cyc  = cyc + e.k + 1;
        if (d_gnt) begin
          e.data    = e.err ? 64'd0 : (d_we ? model_d : mem_rdata);
          model_d   = e.data;
          exp_addr  = d_addr;
          exp_we    = d_we;
          exp_wdata = d_wdata;
        end else begin
          e.data    = e.err ? 64'd0 : (i_addr[2] ? {32'd0, mem_rdata[63:32]}
                                                 : {32'd0, mem_rdata[31:0]});
          exp_addr  = i_addr;
          exp_we    = 1'b0;
          exp_wdata = 64'd0;
        end
        sb.push_back(e);
        gnt_log.push_back(d_gnt);
        gnt_cyc.push_back(cyc);
        req_hi = 0;
      end

      if (m_req) begin
        req_hi++;
        check_value("m_addr", m_addr, exp_addr);
        check_value("m_we", {63'd0, m_we}, {63'd0, exp_we});
        check_value("m_wdata", m_wdata, exp_wdata);
      end
    end
  end

  // One clock of stimulus: requesters drop (or re-raise) after a grant, and
  // the memory model produces m_ack.
  task automatic step();
    @(posedge clk);
    #1;
    if (saw_i_gnt) i_req = i_hold;
    if (saw_d_gnt) d_req = d_hold;
    if (m_req) begin
      req_cnt++;
      m_ack = (ack_delay > 0) && (req_cnt == ack_delay);
    end else begin
      req_cnt = 0;
      m_ack   = force_ack;
    end
    m_rdata = m_ack ? mem_rdata : ~mem_rdata;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || m_req || i_req || d_req) && n < 200) begin
      step();
      n++;
    end
    check_value({tag, "_done"}, {63'd0, n >= 200}, 64'd0);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_ctl"}, {56'd0, i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we},
                64'd0);
    check_value({tag, "_maddr"}, m_addr, 64'd0);
    check_value({tag, "_mwdata"}, m_wdata, 64'd0);
    check_value({tag, "_irdata"}, {32'd0, i_rdata}, 64'd0);
    check_value({tag, "_drdata"}, d_rdata, 64'd0);
  endtask

  initial begin
    bit fair_exp[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int n;
    int rv_before;

    rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_ack = 0; m_rdata = '0; mem_rdata = '0; ack_delay = 1; force_ack = 0; req_cnt = 0;
    i_hold = 0; d_hold = 0; model_d = '0; exp_addr = '0; exp_wdata = '0; exp_we = 0; req_hi = 0;

    step(); step();
    rst = 1'b0;
    check_all_zero("reset");

    // I fetch from 0x104: upper word of the beat
    ack_delay = 1; mem_rdata = 64'hDEADBEEF_12345678;
    i_addr = 64'h104; i_req = 1;
    #1 check_value("fetch_gnt", {63'd0, i_gnt}, 64'd1);
    wait_idle("fetch");

    // Simultaneous requests: D first, I two cycles later
    gnt_log.delete(); gnt_cyc.delete();
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    i_addr = 64'h200; d_addr = 64'h300; d_we = 0; d_wdata = 64'h77;
    i_req = 1; d_req = 1;
    wait_idle("simul");
    check_value("simul_ngnt", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() >= 2) begin
      check_value("simul_first_d", {63'd0, gnt_log[0]}, 64'd1);
      check_value("simul_second_i", {63'd0, gnt_log[1]}, 64'd0);
      check_value("simul_gap", 64'(gnt_cyc[1] - gnt_cyc[0]), 64'd2);
    end

    // Fairness with both requesters held
    gnt_log.delete(); gnt_cyc.delete();
    i_hold = 1; d_hold = 1; i_addr = 64'h1000; d_addr = 64'h2008;
    i_req = 1; d_req = 1;
    n = 0;
    while (gnt_log.size() < 10 && n < 200) begin
      step();
      n++;
    end
    i_hold = 0; d_hold = 0;
    check_value("fair_budget", {63'd0, n >= 200}, 64'd0);
    wait_idle("fair");
    for (int j = 0; j < 10; j++) begin
      if (j < gnt_log.size()) begin
        check_value($sformatf("fair_%0d", j), {63'd0, gnt_log[j]}, {63'd0, fair_exp[j]});
      end
    end

    // Store keeps the previous load data
    mem_rdata = 64'hAA; d_we = 0; d_addr = 64'h48; d_req = 1;
    wait_idle("preload");
    mem_rdata = 64'h1234; d_we = 1; d_addr = 64'h40; d_wdata = 64'h55; d_req = 1;
    wait_idle("store");
    check_value("store_keeps", d_rdata, 64'hAA);

    // Timeout, then ack exactly on the TIMEOUT-th cycle
    d_we = 0; d_addr = 64'h80; mem_rdata = 64'hCAFE; ack_delay = 0; d_req = 1;
    wait_idle("timeout");
    ack_delay = TO; d_req = 1;
    wait_idle("ack_last");

    // Reset in the middle of a data transaction
    ack_delay = 0; d_addr = 64'hC0; d_req = 1;
    step(); step(); step(); step();
    check_value("midop_busy", {63'd0, m_req}, 64'd1);
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    sb.delete();
    model_d = '0;
    rv_before = rv_total;
    force_ack = 1;
    step();
    force_ack = 0;
    step(); step(); step();
    check_value("late_ack", 64'(rv_total - rv_before), 64'd0);
    ack_delay = 2; mem_rdata = 64'h5555_6666_7777_8888; i_addr = 64'h10; i_req = 1;
    #1 check_value("post_rst_gnt", {63'd0, i_gnt}, 64'd1);
    wait_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single memory port between instruction fetch (pc/inst side) and data access (Addr/Dout/Db side). It sequences one outstanding transaction at a time, with bounded-fairness priority and a watchdog timeout. It sits between the CPU core and a unified memory model, so the core can run against a single-ported, variable-latency memory instead of ideal split i$/d$.

## Interface
Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, memory data width.
- MAX_D_STREAK, 4, maximum consecutive D grants while an I request is pending. Range 1..15.
- TIMEOUT, 255, maximum cycles m_req stays high without m_ack. Range ≥1.

Ports (clock and reset first):
- clk  in  1  single clock, all state on posedge.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  fetch request; held with i_addr until i_gnt.
- i_addr  in  ADDR_W  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle (combinational, IDLE only).
- i_rvalid  out  1  one-cycle fetch completion pulse.
- i_rdata  out  32  instruction word.
- i_err  out  1  valid with i_rvalid; 1 = timed out.
- d_req, d_we  in  1  data request; d_we=1 selects store. Held until d_gnt.
- d_addr  in  ADDR_W; d_wdata  in  DATA_W.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse, for loads and stores.
- d_rdata  out  DATA_W  load data.
- d_err  out  1  valid with d_rvalid.
- m_req  out  1  memory request, held until m_ack or timeout.
- m_we  out  1; m_addr  out  ADDR_W; m_wdata  out  DATA_W.
- m_ack  in  1  memory completion; m_rdata is valid in the same cycle.
- m_rdata  in  DATA_W.

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY.
- **IDLE:**
  - If no request: stay in IDLE.
  - Otherwise pick a winner, pulse its gnt, and register m_addr/m_we/m_wdata. Next state is I_BUSY or D_BUSY, with m_req=1.
  - I grants drive m_we=0 and m_wdata=0.
- **Arbitration:**
  - D wins over I, except when d_streak==MAX_D_STREAK; then I wins.
  - d_streak +1 on a D grant while i_req=1, saturating at MAX_D_STREAK.
  - d_streak resets to 0 on any I grant, and on a D grant with i_req=0.
- **BUSY, m_ack=1:**
  - Drop m_req and return to IDLE.
  - Next cycle, pulse x_rvalid with x_err=0.
  - I: i_rdata = i_addr_q[2] ? m_rdata[63:32] : m_rdata[31:0], where i_addr_q is the addr bit latched at grant.
  - D load: d_rdata = m_rdata. D store: d_rdata holds its previous value.
- **BUSY, timeout:**
  - The watchdog counts cycles with m_req=1.
  - If the TIMEOUT-th cycle passes with no ack: drop m_req, go to IDLE, and pulse next cycle with x_rvalid=1, x_err=1, x_rdata=0.
  - If ack arrives in the TIMEOUT-th cycle, ack wins: normal completion.
- A new grant may occur in the same cycle as the previous rvalid pulse.
- m_ack while in IDLE is ignored: no state change, no pulse.
- x_err is 0 whenever x_rvalid is 0.

## Timing
- Reset values: every output is 0; state=IDLE; d_streak=0; watchdog=0.
- Reset mid-transaction:
  - The cycle after the rst edge has m_req=0 and no rvalid/err.
  - The pending completion is discarded.
  - A late m_ack is ignored.
- Latency, with grant at cycle T and ack at T+k (k≥1):
  - m_req high for T+1..T+k.
  - rvalid at T+k+1.
  - Next grant no earlier than T+k+1.
  - Minimum throughput: one access per 2 cycles.
- m_addr/m_we/m_wdata are stable for the entire m_req-high interval.
- Watchdog counter width is $clog2(TIMEOUT+1); it clears on every grant.

## Structure
- Package mem_arbiter_pkg: arb_state_t enum {IDLE, I_BUSY, D_BUSY}; owner_t enum {OWN_I, OWN_D}.
- Sub-module arb_timer: the watchdog counter, with inputs clear/enable and output expired at count==TIMEOUT.
- Arbitration, streak counter and response registers live in mem_arbiter.

## Test plan
- **I fetch:** i_req with i_addr=0x104; ack 1 cycle after m_req with m_rdata=0xDEADBEEF_12345678.
  - Expect i_gnt@T, m_req@T+1 with m_addr=0x104 and m_we=0.
  - Expect i_rvalid@T+2 with i_rdata=0xDEADBEEF and i_err=0.
- **Simultaneous requests:** i_req and d_req both asserted at T in IDLE, ack latency 1.
  - Expect d_gnt@T and i_gnt@T+2.
  - Expect d_rvalid@T+2 and i_rvalid@T+4.
- **Fairness:** MAX_D_STREAK=4, i_req and d_req held continuously.
  - Expect grant order D,D,D,D,I,D,D,D,D,I.
- **Store:** d_we=1, d_addr=0x40, d_wdata=0x55, prior d_rdata=0xAA.
  - Expect m_we=1, m_wdata=0x55.
  - Expect a d_rvalid pulse with d_err=0 and d_rdata still 0xAA.
- **Timeout:** TIMEOUT=8, D load.
  - With m_ack never asserted: m_req high exactly 8 cycles, then d_rvalid=1, d_err=1, d_rdata=0.
  - Repeat with m_ack on the 8th cycle: normal completion, d_err=0.
- **Reset mid-op:** assert rst during D_BUSY.
  - Next cycle: m_req=0 and all outputs 0.
  - A later m_ack produces no d_rvalid.
  - A following i_req is granted normally in IDLE.
